alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single ALU between two requesters (port 0: instruction issue, port 1: sort/loop engine).
- Accepts one operation at a time over a valid/ready handshake and drives the registered operands onto the ALU.
- Waits a fixed ALU latency, captures the ALU result, and returns it to the owning requester over a valid/ready response channel.

Parameters:
ALU_LAT, 1, posedges from the ALU operand registers updating to alu_ot being valid; legal range 1..15.

Ports:
clk  in  1  system clock, posedge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
req0_a  in  32  operand a
req0_b  in  32  operand b
req0_imm  in  16  immediate
req0_opcode  in  6  ALU opcode
req0_funct  in  6  ALU funct
req1_valid, req1_ready, req1_a, req1_b, req1_imm, req1_opcode, req1_funct  same as port 0, for requester 1
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  32  result for requester 0
rsp1_valid, rsp1_ready, rsp1_data  same as port 0, for requester 1
alu_a  out  32  registered ALU operand a
alu_b  out  32  registered ALU operand b
alu_imm  out  16  registered ALU immediate
alu_opcode  out  6  registered ALU opcode
alu_funct  out  6  registered ALU funct
alu_ot  in  32  ALU result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=0, last_grant=1 (so port 0 wins the first tie).
  - All rsp*_valid=0, all rsp*_data=0, all alu_* outputs=0, counter=0.
  - req*_ready=0 while rst=1.
- States are IDLE, EXEC and RESP.
- IDLE:
  - Grant is combinational. Only one port valid → grant that port. Both valid → grant the port != last_grant.
  - reqN_ready=1 only for the granted port, only in IDLE; all req*_ready=0 in other states.
  - On an edge with valid&ready: register that port's a/b/imm/opcode/funct into alu_*, set owner=N, set counter=ALU_LAT-1, go to EXEC.
- EXEC:
  - counter==0 at the edge → capture alu_ot into rsp[owner]_data, set rsp[owner]_valid=1, go to RESP.
  - Otherwise decrement counter.
  - With ALU_LAT=1: accepted at edge k, rsp_valid high after edge k+1.
- RESP:
  - Hold rsp[owner]_valid and rsp[owner]_data stable until rsp[owner]_ready=1 at an edge.
  - At that edge: clear valid, set last_grant=owner, go to IDLE.
  - The other rsp port stays 0 throughout.
- Throughput: minimum one operation per ALU_LAT+2 cycles (accept, ALU_LAT exec, 1 response). The next accept occurs no earlier than the edge after the response handshake.
- alu_* outputs hold their last operation until the next accept; they are never cleared except by rst.
- rsp*_data holds its last captured value after valid drops.
- Requesters hold payload stable while valid&!ready; payload is sampled only at the accept edge.
- Deasserting reqN_valid before ready: allowed; no operation is issued.
- No starvation: with both ports continuously valid, grants alternate 0,1,0,1.
- rsp_ready asserted while rsp_valid=0 is ignored.
- rst mid-EXEC or mid-RESP: the operation is dropped, no response is ever produced, and all state returns to reset values immediately.

Test Plan:
- Single op, port 0: a=5, b=3, opcode=0, funct=0, ALU_LAT=1, rsp0_ready=1 → req0_ready high in cycle 0; rsp0_valid high 1 cycle after accept, rsp0_data=8; rsp1_valid never high.
- Both valid from reset, port 0 funct=1 (a=10, b=4), port 1 opcode=1 (a=7, imm=2) → port 0 served first (rsp0_data=6), then port 1 (rsp1_data=9); ordering 0,1,0,1 over 4 back-to-back ops; each accept is ALU_LAT+2 cycles apart.
- Response backpressure: rsp1_ready=0 for 5 cycles → rsp1_valid/rsp1_data stable; no req*_ready during the stall; next accept on the cycle after rsp1_ready=1.
- ALU_LAT=3, port 1 funct=6, a=1, b=4 → rsp1_data=16, rsp1_valid rises exactly 3 edges after the accept edge.
- Async rst pulse mid-EXEC (between edges) → all outputs go to 0 immediately without a clock edge; no rsp*_valid afterwards; a new port 0 op then completes normally with a correct result.
- Port 0 valid drops before being granted while port 1 is busy → no operation issued for port 0, rsp0_valid stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
// Accepts one op at a time, waits ALU_LAT edges for alu_ot, returns it to the owner.
module alu_arbiter #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [15:0] req0_imm,
   input  logic [5:0]  req0_opcode,
   input  logic [5:0]  req0_funct,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [15:0] req1_imm,
   input  logic [5:0]  req1_opcode,
   input  logic [5:0]  req1_funct,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,

   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,

   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [15:0] alu_imm,
   output logic [5:0]  alu_opcode,
   output logic [5:0]  alu_funct,
   input  logic [31:0] alu_ot
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [15:0] alu_imm_q, alu_imm_d;
   logic [5:0]  alu_opcode_q, alu_opcode_d;
   logic [5:0]  alu_funct_q, alu_funct_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp0_data_q, rsp0_data_d;
   logic [31:0] rsp1_data_q, rsp1_data_d;

   logic        grant_any;
   logic        grant_sel;
   logic        accept;
   logic        rsp_done;

   always_comb begin
      grant_any = req0_valid | req1_valid;
      // On a tie the port that did not own the previous operation goes next.
      grant_sel = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      accept    = (state_q == IDLE) & grant_any & ~rst;
      rsp_done  = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);
   end

   assign req0_ready = accept & ~grant_sel;
   assign req1_ready = accept &  grant_sel;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_imm_d    = alu_imm_q;
      alu_opcode_d = alu_opcode_q;
      alu_funct_d  = alu_funct_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp1_data_d  = rsp1_data_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = grant_sel;
               cnt_d   = CNT_INIT;
               state_d = EXEC;
               if (grant_sel) begin
                  alu_a_d      = req1_a;
                  alu_b_d      = req1_b;
                  alu_imm_d    = req1_imm;
                  alu_opcode_d = req1_opcode;
                  alu_funct_d  = req1_funct;
               end else begin
                  alu_a_d      = req0_a;
                  alu_b_d      = req0_b;
                  alu_imm_d    = req0_imm;
                  alu_opcode_d = req0_opcode;
                  alu_funct_d  = req0_funct;
               end
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (owner_q) begin
                  rsp1_data_d  = alu_ot;
                  rsp1_valid_d = 1'b1;
               end else begin
                  rsp0_data_d  = alu_ot;
                  rsp0_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_done) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               last_d       = owner_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= 4'd0;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         alu_imm_q    <= 16'd0;
         alu_opcode_q <= 6'd0;
         alu_funct_q  <= 6'd0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= 32'd0;
         rsp1_data_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_imm_q    <= alu_imm_d;
         alu_opcode_q <= alu_opcode_d;
         alu_funct_q  <= alu_funct_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_imm    = alu_imm_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_funct  = alu_funct_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter at ALU_LAT=1 and ALU_LAT=3
// Instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3; both share clk and rst.
module tb_alu_arbiter;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic [5:0]  op;
      logic [5:0]  fn;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        rv [2][2];
   logic        rr [2][2];
   op_t         rq [2][2];
   logic        sv [2][2];
   logic        sr [2][2];
   logic [31:0] sd [2][2];
   logic [31:0] aa [2];
   logic [31:0] ab [2];
   logic [15:0] aimm [2];
   logic [5:0]  aop [2];
   logic [5:0]  afn [2];
   logic [31:0] aot [2];
   op_t         alu_now [2];

   int vectors = 0;
   int miscompares = 0;

   alu_arbiter #(.ALU_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(rv[0][0]), .req0_ready(rr[0][0]), .req0_a(rq[0][0].a), .req0_b(rq[0][0].b),
      .req0_imm(rq[0][0].imm), .req0_opcode(rq[0][0].op), .req0_funct(rq[0][0].fn),
      .req1_valid(rv[0][1]), .req1_ready(rr[0][1]), .req1_a(rq[0][1].a), .req1_b(rq[0][1].b),
      .req1_imm(rq[0][1].imm), .req1_opcode(rq[0][1].op), .req1_funct(rq[0][1].fn),
      .rsp0_valid(sv[0][0]), .rsp0_ready(sr[0][0]), .rsp0_data(sd[0][0]),
      .rsp1_valid(sv[0][1]), .rsp1_ready(sr[0][1]), .rsp1_data(sd[0][1]),
      .alu_a(aa[0]), .alu_b(ab[0]), .alu_imm(aimm[0]), .alu_opcode(aop[0]), .alu_funct(afn[0]),
      .alu_ot(aot[0])
   );

   alu_arbiter #(.ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(rv[1][0]), .req0_ready(rr[1][0]), .req0_a(rq[1][0].a), .req0_b(rq[1][0].b),
      .req0_imm(rq[1][0].imm), .req0_opcode(rq[1][0].op), .req0_funct(rq[1][0].fn),
      .req1_valid(rv[1][1]), .req1_ready(rr[1][1]), .req1_a(rq[1][1].a), .req1_b(rq[1][1].b),
      .req1_imm(rq[1][1].imm), .req1_opcode(rq[1][1].op), .req1_funct(rq[1][1].fn),
      .rsp0_valid(sv[1][0]), .rsp0_ready(sr[1][0]), .rsp0_data(sd[1][0]),
      .rsp1_valid(sv[1][1]), .rsp1_ready(sr[1][1]), .rsp1_data(sd[1][1]),
      .alu_a(aa[1]), .alu_b(ab[1]), .alu_imm(aimm[1]), .alu_opcode(aop[1]), .alu_funct(afn[1]),
      .alu_ot(aot[1])
   );

   function automatic logic [31:0] alu_fn(input op_t o);
      logic [31:0] r;
      case (o.op)
         6'd0: begin
            case (o.fn)
               6'd0:    r = o.a + o.b;
               6'd1:    r = o.a - o.b;
               6'd2:    r = o.a & o.b;
               6'd3:    r = o.a | o.b;
               6'd4:    r = o.a ^ o.b;
               6'd6:    r = o.a << o.b[4:0];
               default: r = ~(o.a ^ o.b);
            endcase
         end
         6'd1:    r = o.a + {{16{o.imm[15]}}, o.imm};
         6'd2:    r = o.a & {16'h0000, o.imm};
         default: r = o.a ^ o.b ^ {16'h0000, o.imm};
      endcase
      return r;
   endfunction

   // ALU stand-in: combinational for instance 0, two extra register stages for instance 1,
   // so a capture one edge early would see the previous operation's result.
   logic [31:0] pipe1 = 32'd0;
   logic [31:0] pipe2 = 32'd0;
   assign alu_now[0] = {aa[0], ab[0], aimm[0], aop[0], afn[0]};
   assign alu_now[1] = {aa[1], ab[1], aimm[1], aop[1], afn[1]};
   assign aot[0] = alu_fn(alu_now[0]);
   assign aot[1] = pipe2;
   always @(posedge clk) begin
      pipe1 <= alu_fn(alu_now[1]);
      pipe2 <= pipe1;
   end

   task automatic chk(input string nm, input int k, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm, input int k);
      vectors++;
      miscompares++;
      $display("FAIL %s inst%0d t=%0t actual=no event required=event within budget", nm, k, $time);
   endtask

   // Behavioural model: an op in flight ages one per edge and its result is due after lat edges.
   int          lat [2] = '{1, 3};
   bit          m_pend [2];
   bit          m_resp [2];
   int          m_age [2];
   int          m_owner [2];
   int          m_last [2];
   logic [31:0] m_data [2][2];
   op_t         m_alu [2];
   int          m_edge = 0;
   int          acc_port [2][$];
   int          acc_edge [2][$];

   function automatic int grant(input int k);
      if (m_pend[k] || m_resp[k]) return -1;
      if (rv[k][0] && rv[k][1]) return (m_last[k] == 0) ? 1 : 0;
      if (rv[k][0]) return 0;
      if (rv[k][1]) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 1'b0;
         m_resp[k] = 1'b0;
         m_age[k] = 0;
         m_owner[k] = 0;
         m_last[k] = 1;
         m_data[k][0] = 32'd0;
         m_data[k][1] = 32'd0;
         m_alu[k] = '0;
      end
   endtask

   task automatic model_step(input int k);
      int g;
      if (m_resp[k]) begin
         if (sr[k][m_owner[k]]) begin
            m_resp[k] = 1'b0;
            m_last[k] = m_owner[k];
         end
      end else if (m_pend[k]) begin
         m_age[k]++;
         if (m_age[k] == lat[k]) begin
            m_data[k][m_owner[k]] = alu_fn(m_alu[k]);
            m_pend[k] = 1'b0;
            m_resp[k] = 1'b1;
         end
      end else begin
         g = grant(k);
         if (g >= 0) begin
            m_alu[k] = rq[k][g];
            m_owner[k] = g;
            m_pend[k] = 1'b1;
            m_age[k] = 0;
            acc_port[k].push_back(g);
            acc_edge[k].push_back(m_edge);
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            m_edge++;
            for (int k = 0; k < 2; k++) model_step(k);
         end
      end
   end

   // Compare process: every output of both instances against the model at each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("req%0d_ready", p), k, 96'(rr[k][p]), 96'((grant(k) == p) && !rst));
               chk($sformatf("rsp%0d_valid", p), k, 96'(sv[k][p]), 96'(m_resp[k] && (m_owner[k] == p)));
               chk($sformatf("rsp%0d_data", p), k, 96'(sd[k][p]), 96'(m_data[k][p]));
            end
            chk("alu_operands", k, 96'(alu_now[k]), 96'(m_alu[k]));
         end
      end
   end

   // Requester/responder driver: presents queue heads, pops on handshake, sets rsp ready.
   op_t opq [2][2][$];
   int  rsp_mode [2][2];
   bit  rand_drop = 1'b0;
   bit  hs [2][2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            rv[k][p] = 1'b0;
            rq[k][p] = '0;
            sr[k][p] = 1'b1;
            rsp_mode[k][p] = 0;
         end
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
               hs[k][p] = rv[k][p] && rr[k][p];
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
               if (hs[k][p] && opq[k][p].size() > 0) void'(opq[k][p].pop_front());
               if (opq[k][p].size() > 0 && !(rand_drop && $urandom_range(0, 3) == 0)) begin
                  rv[k][p] = 1'b1;
                  rq[k][p] = opq[k][p][0];
               end else begin
                  rv[k][p] = 1'b0;
                  rq[k][p] = {$urandom, $urandom, 28'($urandom)};
               end
               case (rsp_mode[k][p])
                  0:       sr[k][p] = 1'b1;
                  1:       sr[k][p] = 1'b0;
                  default: sr[k][p] = 1'($urandom_range(0, 1));
               endcase
            end
         end
      end
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input int k, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [5:0] op, input logic [5:0] fn);
      op_t o;
      o.a = a; o.b = b; o.imm = imm; o.op = op; o.fn = fn;
      opq[k][p].push_back(o);
   endtask

   task automatic wait_rsp(input int k, input int p, input logic [31:0] exp, output int e_at);
      e_at = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sv[k][p] === 1'b1) begin
            e_at = m_edge;
            break;
         end
      end
      if (e_at < 0) timeout_fail($sformatf("rsp%0d_timeout", p), k);
      else chk($sformatf("rsp%0d_literal", p), k, 96'(sd[k][p]), 96'(exp));
      #1;
   endtask

   task automatic wait_acc(input int k, input int n);
      for (int i = 0; i < 200; i++) begin
         if (acc_port[k].size() >= n) break;
         @(negedge clk);
         #1;
      end
      if (acc_port[k].size() < n) timeout_fail("accept_timeout", k);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog t=%0t actual=still running required=finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int e_at, n0, n1, seen, hs_edge, total;
      nclk(2);
      for (int k = 0; k < 2; k++) begin
         chk("reset_req0_ready", k, 96'(rr[k][0]), 96'd0);
         chk("reset_rsp1_valid", k, 96'(sv[k][1]), 96'd0);
         chk("reset_alu_a", k, 96'(aa[k]), 96'd0);
      end
      rst = 1'b0;

      // single op on port 0
      push(0, 0, 32'd5, 32'd3, 16'd0, 6'd0, 6'd0);
      @(negedge clk);
      chk("t1_req0_ready", 0, 96'(rr[0][0]), 96'd1);
      wait_rsp(0, 0, 32'd8, e_at);
      chk("t1_latency", 0, 96'(e_at - acc_edge[0][0]), 96'd1);
      nclk(2);

      // both valid from reset: 0,1,0,1 spaced ALU_LAT+2
      rst = 1'b1;
      #2;
      rst = 1'b0;
      acc_port[0].delete();
      acc_edge[0].delete();
      push(0, 0, 32'd10, 32'd4, 16'd0, 6'd0, 6'd1);
      push(0, 0, 32'd20, 32'd5, 16'd0, 6'd0, 6'd0);
      push(0, 1, 32'd7, 32'd0, 16'd2, 6'd1, 6'd0);
      push(0, 1, 32'd100, 32'd0, 16'hFFFF, 6'd1, 6'd0);
      wait_rsp(0, 0, 32'd6, e_at);
      wait_rsp(0, 1, 32'd9, e_at);
      wait_acc(0, 4);
      if (acc_port[0].size() >= 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), 0, 96'(acc_port[0][i]), 96'(i % 2));
         for (int i = 1; i < 4; i++)
            chk($sformatf("t2_spacing%0d", i), 0, 96'(acc_edge[0][i] - acc_edge[0][i-1]), 96'd3);
      end
      wait_rsp(0, 1, 32'd99, e_at);
      nclk(3);

      // response backpressure on port 1 with port 0 waiting
      rsp_mode[0][1] = 1;
      n0 = acc_port[0].size();
      push(0, 1, 32'hDEAD0000, 32'h0000BEEF, 16'd0, 6'd0, 6'd0);
      wait_acc(0, n0 + 1);
      push(0, 0, 32'd3, 32'd4, 16'd0, 6'd0, 6'd3);
      wait_rsp(0, 1, 32'hDEADBEEF, e_at);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_rsp1_data_hold", 0, 96'(sd[0][1]), 96'hDEADBEEF);
         chk("t3_rsp1_valid_hold", 0, 96'(sv[0][1]), 96'd1);
         chk("t3_req0_ready_stall", 0, 96'(rr[0][0]), 96'd0);
      end
      #1;
      rsp_mode[0][1] = 0;
      hs_edge = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sr[0][1] === 1'b1) begin
            hs_edge = m_edge + 1;
            break;
         end
      end
      #1;
      wait_acc(0, n0 + 2);
      if (acc_edge[0].size() >= n0 + 2)
         chk("t3_next_accept", 0, 96'(acc_edge[0][n0 + 1] - hs_edge), 96'd1);
      wait_rsp(0, 0, 32'd7, e_at);
      nclk(2);

      // ALU_LAT=3 shift op on port 1
      n1 = acc_port[1].size();
      push(1, 1, 32'd1, 32'd4, 16'd0, 6'd0, 6'd6);
      wait_rsp(1, 1, 32'd16, e_at);
      if (acc_edge[1].size() > n1) chk("t4_latency", 1, 96'(e_at - acc_edge[1][n1]), 96'd3);
      nclk(2);

      // asynchronous reset pulse mid-EXEC
      n1 = acc_port[1].size();
      push(1, 0, 32'h12345678, 32'h11111111, 16'd0, 6'd0, 6'd0);
      wait_acc(1, n1 + 1);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            chk("t5_rst_rsp_valid", k, 96'(sv[k][p]), 96'd0);
            chk("t5_rst_rsp_data", k, 96'(sd[k][p]), 96'd0);
            chk("t5_rst_req_ready", k, 96'(rr[k][p]), 96'd0);
         end
         chk("t5_rst_alu_a", k, 96'(aa[k]), 96'd0);
      end
      #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sv[1][0] === 1'b1 || sv[1][1] === 1'b1) seen++;
      end
      #1;
      chk("t5_no_rsp_after_rst", 1, 96'(seen), 96'd0);
      push(1, 0, 32'd9, 32'd3, 16'd0, 6'd0, 6'd2);
      wait_rsp(1, 0, 32'd1, e_at);
      nclk(2);

      // port 0 withdraws while port 1 holds the ALU
      rsp_mode[0][1] = 1;
      n0 = acc_port[0].size();
      push(0, 1, 32'd50, 32'd8, 16'd0, 6'd0, 6'd1);
      wait_acc(0, n0 + 1);
      push(0, 0, 32'd77, 32'd1, 16'd0, 6'd0, 6'd0);
      nclk(3);
      opq[0][0].delete();
      nclk(2);
      rsp_mode[0][1] = 0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sv[0][0] === 1'b1) seen++;
      end
      #1;
      chk("t6_no_rsp0", 0, 96'(seen), 96'd0);
      chk("t6_accepts", 0, 96'(acc_port[0].size()), 96'(n0 + 1));
      chk("t6_rsp1_data", 0, 96'(sd[0][1]), 96'd42);

      // randomized traffic on both instances
      rand_drop = 1'b1;
      n0 = acc_port[0].size();
      n1 = acc_port[1].size();
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            rsp_mode[k][p] = 2;
            for (int i = 0; i < 30; i++)
               push(k, p, $urandom, $urandom, 16'($urandom_range(0, 65535)),
                    6'($urandom_range(0, 3)), 6'($urandom_range(0, 7)));
         end
      end
      for (int i = 0; i < 5000; i++) begin
         total = opq[0][0].size() + opq[0][1].size() + opq[1][0].size() + opq[1][1].size();
         if (total == 0 && !m_pend[0] && !m_resp[0] && !m_pend[1] && !m_resp[1]) break;
         nclk(1);
      end
      if (total != 0 || m_pend[0] || m_resp[0] || m_pend[1] || m_resp[1]) timeout_fail("t7_drain", 0);
      chk("t7_accept_count", 0, 96'(acc_port[0].size() - n0), 96'd60);
      chk("t7_accept_count", 1, 96'(acc_port[1].size() - n1), 96'd60);
      nclk(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
